sterownik_obrotow: RTL and testbench

STEROWNIK_OBROTOW -- requirements
Module: sterownik_obrotow

---
 rtl/sterownik_pkg.sv | 42 ++++
 rtl/dzielnik_sekwencyjny.sv | 71 +++++++
 rtl/sterownik_obrotow.sv | 186 ++++++++++++++++++
 tb/tb_sterownik_obrotow.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sterownik_pkg.sv
// rtl/sterownik_pkg.sv - shared types, widths and constants for the crank speed controller
//
// Purpose: state enum, output codes and field widths used by sterownik_obrotow
//          and dzielnik_sekwencyjny, plus the ramp-step helper.
// Ports:   none (package).

package sterownik_pkg;

    localparam int RPM_W   = 7;
    localparam int TAKT_W  = 9;
    localparam int TIMER_W = 20;
    localparam int DZIEL_W = 16;

    // Output code meaning "engine stopped"; never produced while running.
    localparam logic [TAKT_W-1:0] TAKT_STOP = 9'h1FF;
    localparam logic [TAKT_W-1:0] TAKT_MAX  = 9'd510;

    typedef enum logic [2:0] {
        STOP   = 3'd0,
        DZIEL  = 3'd1,
        ZMIANA = 3'd2,
        CZEKAJ = 3'd3,
        PRACA  = 3'd4
    } stan_t;

    // Moves rpm_akt towards cel by at most krok.
    function automatic logic [RPM_W-1:0] nastepne_rpm(
        input logic [RPM_W-1:0] rpm_akt,
        input logic [RPM_W-1:0] cel,
        input logic [RPM_W-1:0] krok
    );
        logic [RPM_W-1:0] roznica;
        if (cel > rpm_akt) begin
            roznica = cel - rpm_akt;
            return rpm_akt + ((roznica < krok) ? roznica : krok);
        end else begin
            roznica = rpm_akt - cel;
            return rpm_akt - ((roznica < krok) ? roznica : krok);
        end
    endfunction

endpackage

// File: rtl/dzielnik_sekwencyjny.sv
// rtl/dzielnik_sekwencyjny.sv - 16/7 restoring divider, one quotient bit per clock
//
// Purpose: computes i_dzielna / i_dzielnik in exactly 16 cycles after i_start.
// Ports:   i_clk, i_rst (async, active-high)
//          i_start     - load operands and begin (divisor must be non-zero)
//          i_dzielna   - 16-bit dividend
//          i_dzielnik  - 7-bit divisor
//          o_iloraz    - 16-bit quotient, held until the next i_start
//          o_gotowe    - one-cycle pulse, 16 cycles after i_start

module dzielnik_sekwencyjny
    import sterownik_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic [DZIEL_W-1:0] i_dzielna,
    input  logic [RPM_W-1:0]   i_dzielnik,
    output logic [DZIEL_W-1:0] o_iloraz,
    output logic               o_gotowe
);

    logic [RPM_W-1:0]   r_reszta;
    logic [DZIEL_W-1:0] r_iloraz;
    logic [RPM_W-1:0]   r_dzielnik;
    logic [4:0]         r_licznik;
    logic               r_gotowe;

    // The dividend shifts out of the top of r_iloraz while quotient bits
    // shift in at the bottom.
    logic [RPM_W:0]   w_przes;
    logic [RPM_W+1:0] w_roznica;

    assign w_przes   = {r_reszta, r_iloraz[DZIEL_W-1]};
    assign w_roznica = {1'b0, w_przes} - {2'b00, r_dzielnik};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_reszta   <= '0;
            r_iloraz   <= '0;
            r_dzielnik <= '0;
            r_licznik  <= '0;
            r_gotowe   <= 1'b0;
        end else begin
            r_gotowe <= 1'b0;
            if (i_start) begin
                r_reszta   <= '0;
                r_iloraz   <= i_dzielna;
                r_dzielnik <= i_dzielnik;
                r_licznik  <= 5'd16;
            end else if (r_licznik != 5'd0) begin
                r_licznik <= r_licznik - 5'd1;
                // Borrow bit clear: trial subtraction fits, keep it.
                if (!w_roznica[RPM_W+1]) begin
                    r_reszta <= w_roznica[RPM_W-1:0];
                    r_iloraz <= {r_iloraz[DZIEL_W-2:0], 1'b1};
                end else begin
                    r_reszta <= w_przes[RPM_W-1:0];
                    r_iloraz <= {r_iloraz[DZIEL_W-2:0], 1'b0};
                end
                if (r_licznik == 5'd1) begin
                    r_gotowe <= 1'b1;
                end
            end
        end
    end

    assign o_iloraz = r_iloraz;
    assign o_gotowe = r_gotowe;

endmodule

// File: rtl/sterownik_obrotow.sv
// rtl/sterownik_obrotow.sv - engine crank speed controller with start-up phase and rpm ramp
//
// Purpose: ramps rpm towards a target in bounded steps and publishes the
//          matching clocks-per-degree value, K_TAKTOW / rpm, saturated to 510.
// Ports:   clk, rst (async, active-high)
//          start, stop              - one-cycle requests (stop wins)
//          rpm_zadane, zadanie_wazne - target rpm and its strobe
//          rpm                      - current rpm
//          taktowanie_na_stopien    - clocks per degree, 9'h1FF when stopped
//          sygnal_zmiany_rpm        - pulse marking a new rpm/taktowanie pair
//          rozruch                  - high during the start-up phase
//          zajety                   - high outside STOP and PRACA

module sterownik_obrotow
    import sterownik_pkg::*;
#(
    parameter logic [DZIEL_W-1:0] K_TAKTOW      = 16'd6000,
    parameter logic [RPM_W-1:0]   RPM_ROZRUCH   = 7'd2,
    parameter logic [TIMER_W-1:0] CZAS_ROZRUCHU = 20'd500000,
    parameter logic [TIMER_W-1:0] OKRES_RAMPY   = 20'd100000,
    parameter logic [RPM_W-1:0]   KROK_RPM      = 7'd1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic [RPM_W-1:0]  rpm_zadane,
    input  logic              zadanie_wazne,
    output logic [RPM_W-1:0]  rpm,
    output logic [TAKT_W-1:0] taktowanie_na_stopien,
    output logic              sygnal_zmiany_rpm,
    output logic              rozruch,
    output logic              zajety
);

    stan_t               r_stan;
    stan_t               w_stan_nast;
    logic [RPM_W-1:0]    r_rpm;
    logic [RPM_W-1:0]    r_rpm_nast;
    logic [RPM_W-1:0]    r_cel;
    logic [TAKT_W-1:0]   r_takt;
    logic [TIMER_W-1:0]  r_timer;
    logic                r_puls;
    logic                r_rozruch;

    logic                w_decyzja;
    logic [RPM_W-1:0]    w_rpm_nast;
    logic                w_dziel_start;
    logic                w_timer_koniec;
    logic [DZIEL_W-1:0]  w_iloraz;
    logic                w_gotowe;

    // The divider is started on the decision edge itself, using the freshly
    // chosen rpm_nast, so the pulse lands 18 edges after the decision.
    dzielnik_sekwencyjny u_dzielnik (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_start    (w_dziel_start),
        .i_dzielna  (K_TAKTOW),
        .i_dzielnik (w_rpm_nast),
        .o_iloraz   (w_iloraz),
        .o_gotowe   (w_gotowe)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stan <= STOP;
        end else begin
            r_stan <= w_stan_nast;
        end
    end

    always_comb begin
        w_stan_nast    = r_stan;
        w_decyzja      = 1'b0;
        w_rpm_nast     = r_rpm_nast;
        w_dziel_start  = 1'b0;
        w_timer_koniec = (r_stan == CZEKAJ) && (r_timer <= TIMER_W'(1));

        case (r_stan)
            STOP: begin
                if (start && !stop) begin
                    w_decyzja  = 1'b1;
                    w_rpm_nast = RPM_ROZRUCH;
                end
            end
            DZIEL: begin
                if (w_gotowe) begin
                    w_stan_nast = ZMIANA;
                end
            end
            ZMIANA: begin
                w_stan_nast = (r_rpm_nast == '0) ? STOP : CZEKAJ;
            end
            CZEKAJ: begin
                if (w_timer_koniec) begin
                    if (r_cel == r_rpm) begin
                        w_stan_nast = PRACA;
                    end else begin
                        w_decyzja  = 1'b1;
                        w_rpm_nast = nastepne_rpm(r_rpm, r_cel, KROK_RPM);
                    end
                end
            end
            PRACA: begin
                if (r_cel != r_rpm) begin
                    w_decyzja  = 1'b1;
                    w_rpm_nast = nastepne_rpm(r_rpm, r_cel, KROK_RPM);
                end
            end
            default: begin
                w_stan_nast = STOP;
            end
        endcase

        // A zero target needs no division: publish the stop code directly.
        if (w_decyzja) begin
            if (w_rpm_nast == '0) begin
                w_stan_nast = ZMIANA;
            end else begin
                w_stan_nast   = DZIEL;
                w_dziel_start = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rpm      <= '0;
            r_rpm_nast <= '0;
            r_cel      <= RPM_ROZRUCH;
            r_takt     <= TAKT_STOP;
            r_timer    <= '0;
            r_puls     <= 1'b0;
            r_rozruch  <= 1'b0;
        end else begin
            r_puls     <= 1'b0;
            r_rpm_nast <= w_rpm_nast;

            // r_cel is the request latch: the newest request overwrites it
            // and is consumed at the next decision point.
            if (stop) begin
                r_cel <= '0;
            end else if (zadanie_wazne) begin
                r_cel <= (rpm_zadane == '0) ? RPM_W'(1) : rpm_zadane;
            end

            case (r_stan)
                STOP: begin
                    if (w_decyzja) begin
                        r_rozruch <= 1'b1;
                    end
                end
                ZMIANA: begin
                    // rpm and taktowanie move together on this single edge.
                    r_rpm  <= r_rpm_nast;
                    r_puls <= 1'b1;
                    if (r_rpm_nast == '0) begin
                        r_takt <= TAKT_STOP;
                    end else begin
                        r_takt  <= (w_iloraz > {7'd0, TAKT_MAX}) ? TAKT_MAX
                                                                 : w_iloraz[TAKT_W-1:0];
                        r_timer <= r_rozruch ? CZAS_ROZRUCHU : OKRES_RAMPY;
                    end
                end
                CZEKAJ: begin
                    if (w_timer_koniec) begin
                        r_timer   <= '0;
                        r_rozruch <= 1'b0;
                    end else begin
                        r_timer <= r_timer - TIMER_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign rpm                   = r_rpm;
    assign taktowanie_na_stopien = r_takt;
    assign sygnal_zmiany_rpm     = r_puls;
    assign rozruch               = r_rozruch;
    assign zajety                = (r_stan != STOP) && (r_stan != PRACA);

endmodule

// File: tb/tb_sterownik_obrotow.sv
// tb/tb_sterownik_obrotow.sv - scoreboard bench for sterownik_obrotow

module tb_sterownik_obrotow;

    typedef struct {
        int rpm;
        int takt;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    // Instance A: KROK_RPM=1
    logic       rst_a, a_start, a_stop, a_wazne;
    logic [6:0] a_zad, a_rpm;
    logic [8:0] a_takt;
    logic       a_puls, a_rozr, a_zaj;

    // Instance B: KROK_RPM=50
    logic       rst_b, b_start, b_stop, b_wazne;
    logic [6:0] b_zad, b_rpm;
    logic [8:0] b_takt;
    logic       b_puls, b_rozr, b_zaj;

    sterownik_obrotow #(
        .CZAS_ROZRUCHU (20'd50),
        .OKRES_RAMPY   (20'd10),
        .KROK_RPM      (7'd1)
    ) u_dut_a (
        .clk                   (clk),
        .rst                   (rst_a),
        .start                 (a_start),
        .stop                  (a_stop),
        .rpm_zadane            (a_zad),
        .zadanie_wazne         (a_wazne),
        .rpm                   (a_rpm),
        .taktowanie_na_stopien (a_takt),
        .sygnal_zmiany_rpm     (a_puls),
        .rozruch               (a_rozr),
        .zajety                (a_zaj)
    );

    sterownik_obrotow #(
        .CZAS_ROZRUCHU (20'd50),
        .OKRES_RAMPY   (20'd10),
        .KROK_RPM      (7'd50)
    ) u_dut_b (
        .clk                   (clk),
        .rst                   (rst_b),
        .start                 (b_start),
        .stop                  (b_stop),
        .rpm_zadane            (b_zad),
        .zadanie_wazne         (b_wazne),
        .rpm                   (b_rpm),
        .taktowanie_na_stopien (b_takt),
        .sygnal_zmiany_rpm     (b_puls),
        .rozruch               (b_rozr),
        .zajety                (b_zaj)
    );

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t e_a;
    exp_t e_b;

    task automatic chk(input string nazwa, input int akt, input int ocz);
        checks++;
        if (akt != ocz) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (cyc=%0d)", nazwa, akt, ocz, cyc);
        end
    endtask

    task automatic push_a(input int r, input int t, input int c);
        exp_t e;
        e.rpm = r; e.takt = t; e.cyc = c;
        q_a.push_back(e);
    endtask

    task automatic push_b(input int r, input int t, input int c);
        exp_t e;
        e.rpm = r; e.takt = t; e.cyc = c;
        q_b.push_back(e);
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Monitors: every pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (a_puls) begin
            if (q_a.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL a_unexpected_pulse actual rpm=%0d takt=%0d expected none (cyc=%0d)",
                         a_rpm, a_takt, cyc);
            end else begin
                e_a = q_a.pop_front();
                chk("a_pulse_cyc", cyc, e_a.cyc);
                chk("a_pulse_rpm", int'(a_rpm), e_a.rpm);
                chk("a_pulse_takt", int'(a_takt), e_a.takt);
            end
        end
    end

    always @(negedge clk) begin
        if (b_puls) begin
            if (q_b.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL b_unexpected_pulse actual rpm=%0d takt=%0d expected none (cyc=%0d)",
                         b_rpm, b_takt, cyc);
            end else begin
                e_b = q_b.pop_front();
                chk("b_pulse_cyc", cyc, e_b.cyc);
                chk("b_pulse_rpm", int'(b_rpm), e_b.rpm);
                chk("b_pulse_takt", int'(b_takt), e_b.takt);
            end
        end
    end

    int t0, t1, t2, t3, t4;

    initial begin
        rst_a = 1'b1; a_start = 1'b0; a_stop = 1'b0; a_wazne = 1'b0; a_zad = 7'd0;
        rst_b = 1'b1; b_start = 1'b0; b_stop = 1'b0; b_wazne = 1'b0; b_zad = 7'd0;
        repeat (3) @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;
        @(negedge clk);

        // Reset state and 1000 idle cycles
        chk("rst_rpm", int'(a_rpm), 0);
        chk("rst_takt", int'(a_takt), 'h1FF);
        chk("rst_rozruch", int'(a_rozr), 0);
        chk("rst_zajety", int'(a_zaj), 0);
        chk("rst_puls", int'(a_puls), 0);
        repeat (1000) @(negedge clk);
        chk("idle_rpm", int'(a_rpm), 0);
        chk("idle_takt", int'(a_takt), 'h1FF);
        chk("idle_b_takt", int'(b_takt), 'h1FF);

        // Ramp up 2..12 with rpm_zadane=12
        a_zad = 7'd12; a_wazne = 1'b1;
        @(negedge clk);
        a_wazne = 1'b0;
        @(negedge clk);
        t0 = cyc;
        a_start = 1'b1;
        push_a(2, 510, t0 + 19);
        for (int r = 3; r <= 12; r++) begin
            push_a(r, (r == 12) ? 500 : 510, t0 + 87 + 28 * (r - 3));
        end
        @(negedge clk);
        a_start = 1'b0;
        wait_until(t0 + 19);
        chk("start_rozruch_hi", int'(a_rozr), 1);
        chk("start_zajety", int'(a_zaj), 1);
        wait_until(t0 + 68);
        chk("rozruch_still_hi", int'(a_rozr), 1);
        wait_until(t0 + 69);
        chk("rozruch_fell", int'(a_rozr), 0);
        wait_until(t0 + 87 + 28 * 9 + 30);
        chk("ramp_final_rpm", int'(a_rpm), 12);
        chk("ramp_final_takt", int'(a_takt), 500);
        chk("ramp_praca_zajety", int'(a_zaj), 0);
        chk("ramp_queue_empty", q_a.size(), 0);

        // New target 14, then stop while dividing for rpm 13
        t1 = cyc;
        a_zad = 7'd14; a_wazne = 1'b1;
        push_a(13, 461, t1 + 20);
        for (int r = 12; r >= 1; r--) begin
            push_a(r, (r == 12) ? 500 : 510, t1 + 48 + 28 * (12 - r));
        end
        push_a(0, 'h1FF, t1 + 367);
        @(negedge clk);
        a_wazne = 1'b0;
        wait_until(t1 + 5);
        a_stop = 1'b1;
        @(negedge clk);
        a_stop = 1'b0;
        wait_until(t1 + 400);
        chk("stop_rpm", int'(a_rpm), 0);
        chk("stop_takt", int'(a_takt), 'h1FF);
        chk("stop_zajety", int'(a_zaj), 0);
        chk("stop_queue_empty", q_a.size(), 0);

        // start and stop together from STOP
        a_start = 1'b1; a_stop = 1'b1;
        @(negedge clk);
        a_start = 1'b0; a_stop = 1'b0;
        repeat (40) @(negedge clk);
        chk("ss_zajety", int'(a_zaj), 0);
        chk("ss_rozruch", int'(a_rozr), 0);
        chk("ss_rpm", int'(a_rpm), 0);

        // Reset in the middle of DZIEL
        t2 = cyc;
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        wait_until(t2 + 6);
        chk("dziel_zajety", int'(a_zaj), 1);
        chk("dziel_rozruch", int'(a_rozr), 1);
        rst_a = 1'b1;
        #1;
        chk("mid_rst_zajety", int'(a_zaj), 0);
        chk("mid_rst_rozruch", int'(a_rozr), 0);
        chk("mid_rst_takt", int'(a_takt), 'h1FF);
        chk("mid_rst_rpm", int'(a_rpm), 0);
        @(negedge clk);
        rst_a = 1'b0;
        repeat (40) @(negedge clk);
        chk("post_rst_zajety", int'(a_zaj), 0);
        chk("post_rst_takt", int'(a_takt), 'h1FF);
        chk("post_rst_queue", q_a.size(), 0);

        // Instance B: big steps 2 -> 12, then 12 -> 62 -> 100
        b_zad = 7'd12; b_wazne = 1'b1;
        @(negedge clk);
        b_wazne = 1'b0;
        @(negedge clk);
        t3 = cyc;
        b_start = 1'b1;
        push_b(2, 510, t3 + 19);
        push_b(12, 500, t3 + 87);
        @(negedge clk);
        b_start = 1'b0;
        wait_until(t3 + 107);
        chk("b_rpm12", int'(b_rpm), 12);
        chk("b_praca12", int'(b_zaj), 0);
        t4 = cyc;
        b_zad = 7'd100; b_wazne = 1'b1;
        push_b(62, 96, t4 + 20);
        push_b(100, 60, t4 + 48);
        @(negedge clk);
        b_wazne = 1'b0;
        wait_until(t4 + 80);
        chk("b_rpm100", int'(b_rpm), 100);
        chk("b_takt60", int'(b_takt), 60);
        chk("b_praca100", int'(b_zaj), 0);
        chk("b_queue_empty", q_b.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
